rc4_ksa_engine: RTL and testbench

Parametrised RC4 key-scheduling engine. It optionally initialises S[i]=i, then runs the KSA swap loop over a single-port S-box RAM of 2^ADDR_W entries. The key length is selectable at run time, up to MAX_KEY_BYTES, and RAM read latency is configurable. It sits between the S-box RAM and the top-level controller, which starts it and waits for done before the keystream (PRGA) stage begins.

---
 rtl/rc4_pkg.sv | 30 +++
 rtl/rc4_key_ptr.sv | 44 ++++
 rtl/rc4_ksa_engine.sv | 177 +++++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
// Module : rc4_pkg
// Brief  : Shared FSM states, key byte width and key_len width helper.
// Rev    : 1.0
// ============================================================================
package rc4_pkg;

    localparam int KEY_BYTE_W = 8;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        INIT   = 4'd1,
        SET_I  = 4'd2,
        WAIT_I = 4'd3,
        CALC_J = 4'd4,
        SET_J  = 4'd5,
        WAIT_J = 4'd6,
        WR_I   = 4'd7,
        WR_J   = 4'd8,
        NEXT   = 4'd9,
        DONE   = 4'd10
    } rc4_state_t;

    function automatic int key_len_w(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_key_ptr.sv
`default_nettype none
// ============================================================================
// Module : rc4_key_ptr
// Brief  : Key byte pointer wrapping at key_len, with combinational byte mux.
// Rev    : 1.0
// ============================================================================
module rc4_key_ptr
    import rc4_pkg::*;
#(
    parameter int MAX_KEY_BYTES = 16
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 clear,
    input  logic                                 advance,
    input  logic [MAX_KEY_BYTES*KEY_BYTE_W-1:0]  key,
    input  logic [key_len_w(MAX_KEY_BYTES)-1:0]  key_len,
    output logic [KEY_BYTE_W-1:0]                key_byte
);

    localparam int c_kl_w = key_len_w(MAX_KEY_BYTES);

    logic [c_kl_w-1:0] r_k;

    // Compare-and-wrap instead of a modulo keeps this to one comparator.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_k <= '0;
        end else if (advance) begin
            r_k <= (r_k == key_len - c_kl_w'(1)) ? '0 : r_k + c_kl_w'(1);
        end
    end

    always_comb begin
        key_byte = '0;
        for (int b = 0; b < MAX_KEY_BYTES; b++) begin
            if (r_k == c_kl_w'(b)) begin
                key_byte = key[b*KEY_BYTE_W +: KEY_BYTE_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rc4_ksa_engine.sv
`default_nettype none
// ============================================================================
// Module : rc4_ksa_engine
// Brief  : RC4 key scheduling over a single-port S-box RAM. mem_rdata is valid
//          RD_LAT cycles after the cycle whose state issues the address.
// Rev    : 1.0
// ============================================================================
module rc4_ksa_engine
    import rc4_pkg::*;
#(
    parameter int ADDR_W        = 8,
    parameter int MAX_KEY_BYTES = 16,
    parameter int RD_LAT        = 1
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic                                 do_init,
    input  logic [MAX_KEY_BYTES*KEY_BYTE_W-1:0]  key,
    input  logic [key_len_w(MAX_KEY_BYTES)-1:0]  key_len,
    output logic [ADDR_W-1:0]                    mem_addr,
    output logic [ADDR_W-1:0]                    mem_wdata,
    output logic                                 mem_wren,
    input  logic [ADDR_W-1:0]                    mem_rdata,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err
);

    localparam int                c_kl_w      = key_len_w(MAX_KEY_BYTES);
    localparam int                c_wc_w      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] c_last_idx  = '1;
    localparam logic [ADDR_W-1:0] c_one       = ADDR_W'(1);
    localparam logic [c_wc_w-1:0] c_wait_last = c_wc_w'(RD_LAT - 1);

    rc4_state_t                          r_state, w_state_next;
    logic [ADDR_W-1:0]                   r_i, r_j, r_s_i, r_s_j;
    logic [c_wc_w-1:0]                   r_wait;
    logic [MAX_KEY_BYTES*KEY_BYTE_W-1:0] r_key;
    logic [c_kl_w-1:0]                   r_key_len;
    logic                                r_err;
    logic [ADDR_W-1:0]                   r_mem_addr, r_mem_wdata;
    logic                                r_mem_wren;
    logic [KEY_BYTE_W-1:0]               w_key_byte;
    logic [ADDR_W-1:0]                   w_key_adj;
    logic                                w_accept, w_key_len_bad, w_wait_done;

    assign w_accept      = (r_state == IDLE) && start;
    assign w_key_len_bad = (key_len == '0) || (key_len > c_kl_w'(MAX_KEY_BYTES));
    assign w_wait_done   = (r_wait == c_wait_last);

    rc4_key_ptr #(
        .MAX_KEY_BYTES (MAX_KEY_BYTES)
    ) u_key_ptr (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (w_accept),
        .advance  (r_state == CALC_J),
        .key      (r_key),
        .key_len  (r_key_len),
        .key_byte (w_key_byte)
    );

    generate
        if (ADDR_W >= KEY_BYTE_W) begin : g_key_wide
            assign w_key_adj = ADDR_W'(w_key_byte);
        end else begin : g_key_narrow
            assign w_key_adj = w_key_byte[ADDR_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_key_len_bad) w_state_next = DONE;
                    else if (do_init)  w_state_next = INIT;
                    else               w_state_next = SET_I;
                end
            end
            INIT:    if (r_i == c_last_idx) w_state_next = SET_I;
            SET_I:   w_state_next = WAIT_I;
            WAIT_I:  if (w_wait_done) w_state_next = CALC_J;
            CALC_J:  w_state_next = SET_J;
            SET_J:   w_state_next = WAIT_J;
            WAIT_J:  if (w_wait_done) w_state_next = (r_j == r_i) ? NEXT : WR_I;
            WR_I:    w_state_next = WR_J;
            WR_J:    w_state_next = NEXT;
            NEXT:    w_state_next = (r_i == c_last_idx) ? DONE : SET_I;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Write enable defaults low so each write is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_i         <= '0;
            r_j         <= '0;
            r_s_i       <= '0;
            r_s_j       <= '0;
            r_wait      <= '0;
            r_key       <= '0;
            r_key_len   <= '0;
            r_err       <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wren  <= 1'b0;
        end else begin
            r_mem_wren <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_key     <= key;
                        r_key_len <= key_len;
                        r_err     <= w_key_len_bad;
                        r_i       <= '0;
                        r_j       <= '0;
                    end
                end
                INIT: begin
                    r_mem_addr  <= r_i;
                    r_mem_wdata <= r_i;
                    r_mem_wren  <= 1'b1;
                    r_i         <= r_i + c_one;
                end
                SET_I: begin
                    r_mem_addr <= r_i;
                    r_wait     <= '0;
                end
                WAIT_I: begin
                    r_wait <= r_wait + c_wc_w'(1);
                    if (w_wait_done) r_s_i <= mem_rdata;
                end
                CALC_J: r_j <= r_j + r_s_i + w_key_adj;
                SET_J: begin
                    r_mem_addr <= r_j;
                    r_wait     <= '0;
                end
                WAIT_J: begin
                    r_wait <= r_wait + c_wc_w'(1);
                    if (w_wait_done) r_s_j <= mem_rdata;
                end
                WR_I: begin
                    r_mem_addr  <= r_i;
                    r_mem_wdata <= r_s_j;
                    r_mem_wren  <= 1'b1;
                end
                WR_J: begin
                    r_mem_addr  <= r_j;
                    r_mem_wdata <= r_s_i;
                    r_mem_wren  <= 1'b1;
                end
                NEXT:    r_i <= r_i + c_one;
                default: ;
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wren  = r_mem_wren;
    assign busy      = (r_state != IDLE) && (r_state != DONE);
    assign done      = (r_state == DONE);
    assign err       = (r_state == DONE) && r_err;

endmodule
`default_nettype wire

// File: tb/tb_rc4_ksa_engine.sv
`default_nettype none
// ============================================================================
// Module : tb_rc4_ksa_engine
// Brief  : Scoreboard bench for rc4_ksa_engine against a software KSA model.
// Rev    : 1.0
// ============================================================================
module tb_rc4_ksa_engine;
    import rc4_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         do_init;
    logic [127:0] key;
    logic [4:0]   key_len;
    logic         start_a, start_b, start_c;

    logic [7:0] addr_a, wdata_a, rdata_a, addr_b, wdata_b, rdata_b;
    logic [1:0] addr_c, wdata_c, rdata_c;
    logic       wren_a, busy_a, done_a, err_a;
    logic       wren_b, busy_b, done_b, err_b;
    logic       wren_c, busy_c, done_c, err_c;

    logic [7:0] ram_a [256];
    logic [7:0] ram_b [256];
    logic [1:0] ram_c [4];
    logic [7:0] pipe_b0, pipe_b1;

    int n_checks = 0, n_errs = 0;
    int wc_a = 0, wc_b = 0, wc_c = 0;
    int model_s [256];
    int exp_iter, exp_swaps;
    int sb_q [$];

    always #5 clk = ~clk;

    rc4_ksa_engine #(.ADDR_W(8), .MAX_KEY_BYTES(16), .RD_LAT(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .do_init(do_init), .key(key),
        .key_len(key_len), .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wren(wren_a),
        .mem_rdata(rdata_a), .busy(busy_a), .done(done_a), .err(err_a));

    rc4_ksa_engine #(.ADDR_W(8), .MAX_KEY_BYTES(16), .RD_LAT(3)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .do_init(do_init), .key(key),
        .key_len(key_len), .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wren(wren_b),
        .mem_rdata(rdata_b), .busy(busy_b), .done(done_b), .err(err_b));

    rc4_ksa_engine #(.ADDR_W(2), .MAX_KEY_BYTES(16), .RD_LAT(1)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .start(start_c), .do_init(do_init), .key(key),
        .key_len(key_len), .mem_addr(addr_c), .mem_wdata(wdata_c), .mem_wren(wren_c),
        .mem_rdata(rdata_c), .busy(busy_c), .done(done_c), .err(err_c));

    // RAM models: data appears RD_LAT cycles after the addressing state.
    assign rdata_a = ram_a[addr_a];
    assign rdata_c = ram_c[addr_c];
    assign rdata_b = pipe_b1;

    always @(posedge clk) begin
        if (wren_a) ram_a[addr_a] <= wdata_a;
        if (wren_c) ram_c[addr_c] <= wdata_c;
        if (wren_b) ram_b[addr_b] <= wdata_b;
        pipe_b0 <= ram_b[addr_b];
        pipe_b1 <= pipe_b0;
    end

    always @(negedge clk) begin
        if (wren_a) wc_a++;
        if (wren_b) wc_b++;
        if (wren_c) wc_c++;
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int ram_rd(input int sel, input int idx);
        logic [1:0] ci;
        ci = idx[1:0];
        case (sel)
            0:       return int'(ram_a[idx]);
            1:       return int'(ram_b[idx]);
            default: return int'(ram_c[ci]);
        endcase
    endfunction

    function automatic logic dut_done(input int sel);
        case (sel)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic dut_busy(input int sel);
        case (sel)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic dut_err(input int sel);
        case (sel)
            0:       return err_a;
            1:       return err_b;
            default: return err_c;
        endcase
    endfunction

    function automatic int wcount(input int sel);
        case (sel)
            0:       return wc_a;
            1:       return wc_b;
            default: return wc_c;
        endcase
    endfunction

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       start_a = v;
            1:       start_b = v;
            default: start_c = v;
        endcase
    endtask

    // Software KSA on model_s, with cycle and swap bookkeeping.
    task automatic model_ksa(input int n, input int klen, input logic [127:0] kb, input int lat);
        int j, kbyte, t;
        j = 0;
        exp_iter = 0;
        exp_swaps = 0;
        for (int i = 0; i < n; i++) begin
            kbyte = int'(kb[8*(i % klen) +: 8]) % n;
            j = (j + model_s[i] + kbyte) % n;
            if (j == i) begin
                exp_iter += 2*lat + 4;
            end else begin
                exp_iter += 2*lat + 6;
                exp_swaps++;
                t = model_s[i];
                model_s[i] = model_s[j];
                model_s[j] = t;
            end
        end
    endtask

    task automatic run(input int sel, input logic dinit, input int klen,
                       input logic [127:0] kb, input logic disturb, input string tag);
        int n, lat, cyc, w0, exp_cyc;
        n   = (sel == 2) ? 4 : 256;
        lat = (sel == 1) ? 3 : 1;
        if (dinit) for (int i = 0; i < n; i++) model_s[i] = i;
        model_ksa(n, klen, kb, lat);
        for (int i = 0; i < n; i++) sb_q.push_back(model_s[i]);
        exp_cyc = 1 + (dinit ? n : 0) + exp_iter;
        w0 = wcount(sel);
        @(negedge clk);
        do_init = dinit;
        key     = kb;
        key_len = 5'(klen);
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        cyc = 1;
        while (!dut_done(sel) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (disturb && cyc == 5) begin
                check_eq({tag, " busy mid-run"}, int'(dut_busy(sel)), 1);
                key     = ~kb;
                key_len = 5'd7;
                do_init = ~dinit;
                set_start(sel, 1'b1);
            end else if (disturb && cyc == 6) begin
                set_start(sel, 1'b0);
            end
        end
        check_eq({tag, " latency"}, cyc, exp_cyc);
        check_eq({tag, " err"}, int'(dut_err(sel)), 0);
        check_eq({tag, " writes"}, wcount(sel) - w0, (dinit ? n : 0) + 2*exp_swaps);
        // A start coinciding with DONE must not launch a new run.
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        check_eq({tag, " start at done"}, int'(dut_busy(sel)), 0);
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s S[%0d]", tag, i), ram_rd(sel, i), sb_q.pop_front());
        end
    endtask

    task automatic err_run(input int klen, input string tag);
        int w0;
        w0 = wc_a;
        @(negedge clk);
        key_len = 5'(klen);
        do_init = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_eq({tag, " done"}, int'(done_a), 1);
        check_eq({tag, " err"}, int'(err_a), 1);
        check_eq({tag, " busy"}, int'(busy_a), 0);
        @(negedge clk);
        check_eq({tag, " done pulse"}, int'(done_a), 0);
        repeat (3) @(negedge clk);
        check_eq({tag, " no writes"}, wc_a - w0, 0);
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        do_init = 1'b0;
        key     = '0;
        key_len = '0;
        repeat (3) @(negedge clk);
        check_eq("rst addr", int'(addr_a), 0);
        check_eq("rst wdata", int'(wdata_a), 0);
        check_eq("rst wren", int'(wren_a), 0);
        check_eq("rst busy", int'(busy_a), 0);
        check_eq("rst done", int'(done_a), 0);
        check_eq("rst err", int'(err_a), 0);
        reset_n = 1'b1;

        run(2, 1'b1, 1, 128'h0, 1'b0, "n4");
        check_eq("n4 lit S0", ram_rd(2, 0), 0);
        check_eq("n4 lit S1", ram_rd(2, 1), 2);
        check_eq("n4 lit S2", ram_rd(2, 2), 3);
        check_eq("n4 lit S3", ram_rd(2, 3), 1);

        run(0, 1'b1, 3, 128'h3C0300, 1'b0, "lat1");
        run(1, 1'b1, 3, 128'h3C0300, 1'b0, "lat3");

        err_run(0, "klen0");
        err_run(17, "klen17");

        // Abort a run while it is in WR_I.
        @(negedge clk);
        key = 128'h3C0300; key_len = 5'd3; do_init = 1'b1; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cyc = 0;
        while (u_dut_a.r_state != WR_I && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reach WR_I", int'(u_dut_a.r_state == WR_I), 1);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("abort state", int'(u_dut_a.r_state), int'(IDLE));
        check_eq("abort wren", int'(wren_a), 0);
        check_eq("abort busy", int'(busy_a), 0);
        reset_n = 1'b1;

        run(0, 1'b1, 3, 128'h3C0300, 1'b1, "restart");
        run(0, 1'b0, 5, {88'h0, 32'($urandom), 8'($urandom)}, 1'b0, "noinit");
        run(0, 1'b1, 16, {$urandom, $urandom, $urandom, $urandom}, 1'b1, "klen16");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
